// File: rtl/tour_pkg.sv
// tour_pkg: shared types and defaults for the tour-length evaluator.
//   state_t    - controller states (IDLE, CHECK, ISSUE, DRAIN, DONE)
//   *_DEF      - default parameter values for the evaluator
//   pack_addr  - forms the distance-ROM address {city_a, city_b}
package tour_pkg;

    localparam int N_GENES_DEF = 15;
    localparam int GENE_W_DEF  = 10;
    localparam int CITY_W_DEF  = 4;
    localparam int DIST_W_DEF  = 10;
    localparam int SUM_W_DEF   = 12;
    localparam int ROM_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // City a lands in the upper city_w bits, city b in the lower ones.
    // Works for city indices up to 16 bits wide; callers truncate to 2*city_w.
    function automatic logic [31:0] pack_addr(input logic [15:0] a,
                                              input logic [15:0] b,
                                              input int          city_w);
        pack_addr = (32'(a) << city_w) | 32'(b);
    endfunction

endpackage

// File: rtl/tour_distance_acc_sat_accum.sv
// sat_accum: saturating accumulator with sticky overflow.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear of sum and ovf (wins over en)
//   en         - add din to sum this cycle
//   din        - addend, DIST_W bits
//   sum        - running total, clamps at all-ones
//   ovf        - set once the total has clamped; stays set until clr
module sat_accum
    import tour_pkg::*;
#(
    parameter int DIST_W = DIST_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DIST_W-1:0] din,
    output logic [SUM_W-1:0]  sum,
    output logic              ovf
);

    // One extra bit catches the carry out of the SUM_W range.
    logic [SUM_W:0] wide;
    assign wide = {1'b0, sum} + (SUM_W+1)'(din);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (wide[SUM_W]) begin
                // Once clamped, any further add carries out again, so the sum stays pinned.
                sum <= '1;
                ovf <= 1'b1;
            end else begin
                sum <= wide[SUM_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tour_distance_acc.sv
// tour_distance_acc: sums the leg lengths of one chromosome (tour) by
// walking consecutive city pairs through an external pipelined distance ROM.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - request; taken only when busy is low
//   closed_tour - sampled with start; 1 adds the return leg last->first
//   in          - packed chromosome, slot i = in[i*GENE_W +: GENE_W]
//   rom_en      - ROM read strobe, one leg per cycle
//   rom_addr    - {city_a, city_b}
//   rom_data    - leg length, valid ROM_LAT cycles after rom_en
//   out         - tour length, held from done until the next accepted start
//   done        - one-cycle completion pulse
//   busy        - high from the cycle after an accepted start through done
//   ovf, err    - saturation / invalid-gene flags, valid with done
//   dout_debug  - last leg length accumulated
//
// Handshake: start is a request with busy as its inverted ready. A start seen
// while busy is high is dropped without any effect; there is no queueing.
module tour_distance_acc
    import tour_pkg::*;
#(
    parameter int N_GENES = N_GENES_DEF,
    parameter int GENE_W  = GENE_W_DEF,
    parameter int CITY_W  = CITY_W_DEF,
    parameter int DIST_W  = DIST_W_DEF,
    parameter int SUM_W   = SUM_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      closed_tour,
    input  logic [N_GENES*GENE_W-1:0] in,
    output logic                      rom_en,
    output logic [2*CITY_W-1:0]       rom_addr,
    input  logic [DIST_W-1:0]         rom_data,
    output logic [SUM_W-1:0]          out,
    output logic                      done,
    output logic                      busy,
    output logic                      ovf,
    output logic                      err,
    output logic [DIST_W-1:0]         dout_debug
);

    localparam int CNT_W = $clog2(N_GENES + 1);

    state_t            state, state_nx;
    logic [GENE_W-1:0] genes [N_GENES];
    logic              closed_q;
    logic [CNT_W-1:0]  legs, issue_cnt, ret_cnt;
    logic [ROM_LAT-1:0] vpipe;
    logic              start_ok, gene_bad, last_issue, ret_vld;
    logic [CITY_W-1:0] city_a, city_b;
    logic [SUM_W-1:0]  acc;
    logic              acc_ovf;

    assign start_ok   = (state == IDLE) && start;
    assign legs       = closed_q ? CNT_W'(N_GENES) : CNT_W'(N_GENES - 1);
    assign last_issue = (issue_cnt == legs - 1'b1);
    // Oldest stage of the valid pipe marks the cycle rom_data belongs to us.
    assign ret_vld    = vpipe[ROM_LAT-1];

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign rom_en = (state == ISSUE);
    assign rom_addr = rom_en ? (2*CITY_W)'(pack_addr(16'(city_a), 16'(city_b), CITY_W))
                             : '0;

    // Validity uses the full gene slot, not just the city-index bits.
    always_comb begin
        gene_bad = 1'b0;
        for (int i = 0; i < N_GENES; i++) begin
            if ({1'b0, genes[i]} >= (GENE_W+1)'(N_GENES)) gene_bad = 1'b1;
        end
    end

    // Leg k pairs slot k with slot k+1; the closing leg wraps to slot 0.
    always_comb begin
        city_a = '0;
        city_b = '0;
        for (int i = 0; i < N_GENES; i++) begin
            if (issue_cnt == CNT_W'(i)) begin
                city_a = genes[i][CITY_W-1:0];
                city_b = genes[(i + 1) % N_GENES][CITY_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CHECK;
            CHECK:   state_nx = gene_bad ? DONE : ISSUE;
            ISSUE:   if (last_issue) state_nx = DRAIN;
            DRAIN:   if (ret_cnt == legs) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            closed_q   <= 1'b0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            vpipe      <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            out        <= '0;
            dout_debug <= '0;
            for (int i = 0; i < N_GENES; i++) genes[i] <= '0;
        end else begin
            state <= state_nx;
            vpipe <= (vpipe << 1) | ROM_LAT'(rom_en);

            if (start_ok) begin
                for (int i = 0; i < N_GENES; i++) genes[i] <= in[i*GENE_W +: GENE_W];
                closed_q  <= closed_tour;
                issue_cnt <= '0;
                ret_cnt   <= '0;
                err       <= 1'b0;
                ovf       <= 1'b0;
                out       <= '0;
            end

            if (state == CHECK && gene_bad) err <= 1'b1;
            if (state == ISSUE) issue_cnt <= issue_cnt + 1'b1;

            if (ret_vld) begin
                ret_cnt    <= ret_cnt + 1'b1;
                dout_debug <= rom_data;
            end

            // Publish results as DONE is entered so they are valid with done.
            if (state != DONE && state_nx == DONE) begin
                out <= acc;
                ovf <= acc_ovf;
            end
        end
    end

    sat_accum #(
        .DIST_W (DIST_W),
        .SUM_W  (SUM_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (ret_vld),
        .din   (rom_data),
        .sum   (acc),
        .ovf   (acc_ovf)
    );

endmodule

// File: tb/tb_tour_distance_acc.sv
`timescale 1ns/1ps
module tb_tour_distance_acc;

  localparam int N  = 15;
  localparam int GW = 10;
  localparam int CW = 4;
  localparam int DW = 10;
  localparam int SW = 12;
  localparam int W  = N * GW;
  localparam int SMAX = (1 << SW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          closed_tour;
  logic [W-1:0]  in_v;
  logic          rom_max;

  logic          rom_en1, rom_en3;
  logic [2*CW-1:0] rom_addr1, rom_addr3;
  logic [DW-1:0] rom_data1, rom_data3;
  logic [SW-1:0] out1, out3;
  logic          done1, done3, busy1, busy3, ovf1, ovf3, err1, err3;
  logic [DW-1:0] dbg1, dbg3;

  tour_distance_acc #(.N_GENES(N), .GENE_W(GW), .CITY_W(CW), .DIST_W(DW), .SUM_W(SW), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .closed_tour(closed_tour), .in(in_v),
    .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .out(out1), .done(done1), .busy(busy1), .ovf(ovf1), .err(err1), .dout_debug(dbg1));

  tour_distance_acc #(.N_GENES(N), .GENE_W(GW), .CITY_W(CW), .DIST_W(DW), .SUM_W(SW), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .closed_tour(closed_tour), .in(in_v),
    .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .out(out3), .done(done3), .busy(busy3), .ovf(ovf3), .err(err3), .dout_debug(dbg3));

  // ---------------- ROM models: d(a,b) = a+b+1, or 1023 everywhere ----------------
  function automatic logic [DW-1:0] rom_f(input logic [2*CW-1:0] addr);
    int a, b;
    a = int'(addr[2*CW-1:CW]);
    b = int'(addr[CW-1:0]);
    if (rom_max) return '1;
    return DW'(a + b + 1);
  endfunction

  logic [DW-1:0] p1;
  logic [2:0][DW-1:0] p3;
  always @(posedge clk) begin
    p1 <= rom_en1 ? rom_f(rom_addr1) : '0;
    p3 <= {p3[1:0], (rom_en3 ? rom_f(rom_addr3) : DW'(0))};
  end
  assign rom_data1 = p1;
  assign rom_data3 = p3[2];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*CW-1:0] exp_q[$];
  logic [2*CW-1:0] act_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tour length straight from the leg definition.
  // Summing all legs and clamping once equals a sticky clamp, as legs are >= 0.
  function automatic void model(input logic [W-1:0] g, input logic cl, input logic mx,
                                output logic [SW-1:0] o, output logic ov, output logic er,
                                output int legs);
    int gi[N];
    int total;
    er = 1'b0;
    for (int i = 0; i < N; i++) begin
      gi[i] = int'(g[i*GW +: GW]);
      if (gi[i] >= N) er = 1'b1;
    end
    legs = cl ? N : N - 1;
    exp_q.delete();
    total = 0;
    if (!er) begin
      for (int k = 0; k < legs; k++) begin
        int a, b;
        a = gi[k];
        b = gi[(k + 1) % N];
        exp_q.push_back(8'((a << CW) | b));
        total += mx ? 1023 : (a + b + 1);
      end
    end
    ov = 1'b0;
    if (er) o = '0;
    else if (total > SMAX) begin o = SW'(SMAX); ov = 1'b1; end
    else o = SW'(total);
  endfunction

  function automatic logic [W-1:0] pack_const(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*GW +: GW] = GW'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] pack_seq();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*GW +: GW] = GW'(i);
    return r;
  endfunction

  // ---------------- driver ----------------
  // Latency n = number of rising edges after the edge that sampled start.
  task automatic run_txn(input logic [W-1:0] g, input logic cl, input logic mx, input int glitch,
                         output logic [SW-1:0] o1, output logic v1, output logic e1, output int l1,
                         output logic [SW-1:0] o3, output logic v3, output logic e3, output int l3,
                         output int nen, output logic stuck);
    rom_max = mx;
    @(negedge clk);
    in_v = g; closed_tour = cl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy1), 32'd1);
    act_q.delete();
    l1 = -1; l3 = -1; nen = 0; stuck = 1'b0;
    o1 = '0; v1 = 1'b0; e1 = 1'b0; o3 = '0; v3 = 1'b0; e3 = 1'b0;
    for (int n = 1; n <= 100 && (l1 < 0 || l3 < 0); n++) begin
      if (n == glitch) begin start = 1'b1; in_v = ~g; closed_tour = ~cl; end
      @(posedge clk); #1;
      if (n == glitch) start = 1'b0;
      if (rom_en1) begin nen++; act_q.push_back(rom_addr1); end
      if (l1 >= 0 && done1) stuck = 1'b1;
      if (done1 && l1 < 0) begin l1 = n; o1 = out1; v1 = ovf1; e1 = err1; end
      if (done3 && l3 < 0) begin l3 = n; o3 = out3; v3 = ovf3; e3 = err3; end
    end
    @(posedge clk); #1;
    if (done1 || done3) stuck = 1'b1;
  endtask

  function automatic logic addr_match();
    if (act_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (act_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Checks one finished transaction against the model's expectations.
  task automatic check_txn(input logic [W-1:0] g, input logic cl, input logic mx, input int glitch);
    logic [SW-1:0] o1, o3, eo;
    logic v1, e1, v3, e3, eov, eer, stuck;
    int l1, l3, nen, legs;
    model(g, cl, mx, eo, eov, eer, legs);
    run_txn(g, cl, mx, glitch, o1, v1, e1, l1, o3, v3, e3, l3, nen, stuck);
    chk("out_lat1", 32'(o1), 32'(eo));
    chk("ovf_lat1", 32'(v1), 32'(eov));
    chk("err_lat1", 32'(e1), 32'(eer));
    chk("out_lat3", 32'(o3), 32'(eo));
    chk("ovf_lat3", 32'(v3), 32'(eov));
    chk("err_lat3", 32'(e3), 32'(eer));
    chk("done_one_cycle", 32'(stuck), 32'd0);
    if (eer) begin
      chk("err_done_within_3", 32'(l1 >= 1 && l1 <= 3), 32'd1);
      chk("err_no_rom_reads", 32'(nen), 32'd0);
    end else begin
      chk("latency_lat1", 32'(l1), 32'(legs + 1 + 2));
      chk("latency_lat3", 32'(l3), 32'(legs + 3 + 2));
      chk("addr_sequence", 32'(addr_match()), 32'd1);
      if (mx) chk("dout_debug_max", 32'(dbg1), 32'd1023);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0]  genes;
    logic          closed;
    logic          maxm;
    logic [SW-1:0] exp_out;
    logic          exp_ovf;
    logic          exp_err;
    int            exp_lat;   // edges from start to done for ROM_LAT=1; -1: error path
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [SW-1:0] o1, o3;
    logic v1, e1, v3, e3, stuck;
    int l1, l3, nen;
    logic [W-1:0] g;

    rst_n = 1'b0; start = 1'b0; closed_tour = 1'b0; in_v = '0; rom_max = 1'b0;

    tbl[0] = '{pack_const(6), 1'b0, 1'b0, 12'd182,  1'b0, 1'b0, 17};
    tbl[1] = '{pack_const(6), 1'b1, 1'b0, 12'd195,  1'b0, 1'b0, 18};
    tbl[2] = '{pack_seq(),    1'b1, 1'b0, 12'd225,  1'b0, 1'b0, 18};
    tbl[3] = '{pack_const(6), 1'b1, 1'b1, 12'd4095, 1'b1, 1'b0, 18};
    g = pack_const(6);
    g[7*GW +: GW] = GW'(15);
    tbl[4] = '{g, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1, -1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",     32'(out1),      32'd0);
    chk("rst_done",    32'(done1),     32'd0);
    chk("rst_busy",    32'(busy1),     32'd0);
    chk("rst_ovf_err", 32'({ovf1, err1}), 32'd0);
    chk("rst_rom_en",  32'(rom_en1),   32'd0);
    chk("rst_rom_addr",32'(rom_addr1), 32'd0);
    chk("rst_dbg",     32'(dbg1),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven directed cases
    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i].genes, tbl[i].closed, tbl[i].maxm, -1,
              o1, v1, e1, l1, o3, v3, e3, l3, nen, stuck);
      chk($sformatf("tbl%0d_out", i), 32'(o1), 32'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_ovf", i), 32'(v1), 32'(tbl[i].exp_ovf));
      chk($sformatf("tbl%0d_err", i), 32'(e1), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_out3", i), 32'(o3), 32'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_stuck", i), 32'(stuck), 32'd0);
      if (tbl[i].exp_lat < 0) begin
        chk($sformatf("tbl%0d_err_lat", i), 32'(l1 >= 1 && l1 <= 3), 32'd1);
        chk($sformatf("tbl%0d_no_rom", i), 32'(nen), 32'd0);
      end else begin
        chk($sformatf("tbl%0d_lat1", i), 32'(l1), 32'(tbl[i].exp_lat));
        chk($sformatf("tbl%0d_lat3", i), 32'(l3), 32'(tbl[i].exp_lat + 2));
        chk($sformatf("tbl%0d_nreads", i), 32'(nen), 32'(tbl[i].closed ? N : N - 1));
      end
      if (i == 2 && act_q.size() == N) begin
        chk("seq_first_addr", 32'(act_q[0]),     32'h01);
        chk("seq_mid_addr",   32'(act_q[13]),    32'hde);
        chk("seq_last_addr",  32'(act_q[N - 1]), 32'he0);
      end
      if (i == 3) chk("tbl3_dbg", 32'(dbg1), 32'd1023);
    end

    // start pulse during ISSUE (with in and closed_tour changing) is ignored
    check_txn(pack_const(6), 1'b0, 1'b0, 5);

    // reset asserted mid-ISSUE
    rom_max = 1'b0;
    @(negedge clk);
    in_v = pack_const(6); closed_tour = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", 32'(busy1 && rom_en1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs1", 32'({out1, done1, busy1, ovf1, err1, rom_en1, rom_addr1, dbg1}), 32'd0);
    chk("mid_rst_outputs3", 32'({out3, done3, busy3, ovf3, err3, rom_en3, rom_addr3, dbg3}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_txn(pack_const(6), 1'b1, 1'b0, -1);

    // randomized tours against the model
    for (int t = 0; t < 25; t++) begin
      logic cl, mx;
      for (int i = 0; i < N; i++) g[i*GW +: GW] = GW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 5) == 0) g[$urandom_range(0, N - 1)*GW +: GW] = GW'($urandom_range(N, 1023));
      cl = 1'($urandom_range(0, 1));
      mx = ($urandom_range(0, 7) == 0);
      check_txn(g, cl, mx, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
